// File: rtl/frontend_redirect_arbiter.sv
// Frontend redirect arbiter: picks backend over predecode, pulses a registered redirect,
// holds fetch_stall for a fixed flush window and tracks instruction-buffer occupancy.
module frontend_redirect_arbiter #(
  parameter int VADDR_SIZE   = 39,
  parameter int FSQ_WIDTH    = 5,
  parameter int IBUF_DEPTH   = 32,
  parameter int MAX_PUSH     = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            be_redirect_en,
  input  logic [VADDR_SIZE-1:0]           be_redirect_pc,
  input  logic [FSQ_WIDTH-1:0]            be_redirect_fsq,
  input  logic                            pd_redirect_en,
  input  logic [VADDR_SIZE-1:0]           pd_redirect_pc,
  input  logic [FSQ_WIDTH-1:0]            pd_redirect_fsq,
  input  logic [$clog2(MAX_PUSH):0]       ibuf_push_num,
  input  logic [$clog2(MAX_PUSH):0]       ibuf_pop_num,
  output logic                            redirect,
  output logic [VADDR_SIZE-1:0]           redirect_pc,
  output logic [FSQ_WIDTH-1:0]            redirect_fsq,
  output logic                            redirect_src,
  output logic                            fetch_stall,
  output logic                            ibuf_full,
  output logic [$clog2(IBUF_DEPTH+1)-1:0] ibuf_count
);

  localparam int CNT_W = $clog2(IBUF_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int FC_W  = $clog2(FLUSH_CYCLES) + 1;

  localparam logic IDLE  = 1'b0;
  localparam logic FLUSH = 1'b1;

  logic             state, state_next;
  logic [FC_W-1:0]  flush_cnt, flush_cnt_next;
  logic             be_acc, pd_acc;
  logic [SUM_W-1:0] sum, pop_ext, diff;
  logic [CNT_W-1:0] count_next;
  logic             full_next;

  assign be_acc = be_redirect_en;
  assign pd_acc = pd_redirect_en && !be_redirect_en && (state == IDLE) && !ibuf_full;

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    if (be_acc || pd_acc) begin
      state_next     = FLUSH;
      flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH) begin
      if (flush_cnt == '0) state_next = IDLE;
      else                 flush_cnt_next = flush_cnt - 1'b1;
    end
  end

  // Backend redirect flushes the ibuf, so that cycle's push/pop traffic is discarded.
  always_comb begin
    sum     = {1'b0, ibuf_count} + SUM_W'(ibuf_push_num);
    pop_ext = SUM_W'(ibuf_pop_num);
    diff    = sum - pop_ext;
    if (be_acc)                        count_next = '0;
    else if (pop_ext > sum)            count_next = '0;
    else if (diff > SUM_W'(IBUF_DEPTH)) count_next = CNT_W'(IBUF_DEPTH);
    else                               count_next = diff[CNT_W-1:0];
    full_next = count_next > CNT_W'(IBUF_DEPTH - MAX_PUSH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      redirect_fsq <= '0;
      redirect_src <= 1'b0;
      fetch_stall  <= 1'b0;
      ibuf_full    <= 1'b0;
      ibuf_count   <= '0;
    end else begin
      state       <= state_next;
      flush_cnt   <= flush_cnt_next;
      redirect    <= be_acc || pd_acc;
      fetch_stall <= (state_next == FLUSH);
      ibuf_full   <= full_next;
      ibuf_count  <= count_next;
      if (be_acc) begin
        redirect_pc  <= be_redirect_pc;
        redirect_fsq <= be_redirect_fsq;
        redirect_src <= 1'b0;
      end else if (pd_acc) begin
        redirect_pc  <= pd_redirect_pc;
        redirect_fsq <= pd_redirect_fsq;
        redirect_src <= 1'b1;
      end
    end
  end

  // Popping more than is present means the ibuf bookkeeping upstream is broken.
  always @(posedge clk) begin
    if (!rst && !be_acc)
      assert (pop_ext <= sum) else $error("ibuf underflow: pop=%0d count+push=%0d", pop_ext, sum);
  end

endmodule

// File: tb/tb_frontend_redirect_arbiter.sv
// Directed bench for frontend_redirect_arbiter: each step queues its expected outputs,
// which are popped and compared one cycle later.
module tb_frontend_redirect_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        be_redirect_en, pd_redirect_en;
  logic [38:0] be_redirect_pc, pd_redirect_pc;
  logic [4:0]  be_redirect_fsq, pd_redirect_fsq;
  logic [3:0]  ibuf_push_num, ibuf_pop_num;
  logic        redirect, redirect_src, fetch_stall, ibuf_full;
  logic [38:0] redirect_pc;
  logic [4:0]  redirect_fsq;
  logic [5:0]  ibuf_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        red;
    logic [38:0] pc;
    logic [4:0]  fsq;
    logic        src;
    logic        stall;
    logic        full;
    logic [5:0]  cnt;
  } exp_t;

  exp_t sb[$];

  frontend_redirect_arbiter dut (
    .clk(clk), .rst(rst),
    .be_redirect_en(be_redirect_en), .be_redirect_pc(be_redirect_pc), .be_redirect_fsq(be_redirect_fsq),
    .pd_redirect_en(pd_redirect_en), .pd_redirect_pc(pd_redirect_pc), .pd_redirect_fsq(pd_redirect_fsq),
    .ibuf_push_num(ibuf_push_num), .ibuf_pop_num(ibuf_pop_num),
    .redirect(redirect), .redirect_pc(redirect_pc), .redirect_fsq(redirect_fsq),
    .redirect_src(redirect_src), .fetch_stall(fetch_stall), .ibuf_full(ibuf_full),
    .ibuf_count(ibuf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic be, input logic [38:0] bpc, input logic [4:0] bfsq,
                      input logic pd, input logic [38:0] ppc, input logic [4:0] pfsq,
                      input logic [3:0] push, input logic [3:0] pop,
                      input logic e_red, input logic [38:0] e_pc, input logic [4:0] e_fsq,
                      input logic e_src, input logic e_stall, input logic e_full,
                      input logic [5:0] e_cnt, input string tag);
    exp_t e, got;
    be_redirect_en = be; be_redirect_pc = bpc; be_redirect_fsq = bfsq;
    pd_redirect_en = pd; pd_redirect_pc = ppc; pd_redirect_fsq = pfsq;
    ibuf_push_num = push; ibuf_pop_num = pop;
    e = '{red: e_red, pc: e_pc, fsq: e_fsq, src: e_src, stall: e_stall, full: e_full, cnt: e_cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ".redirect"}, 64'(redirect), 64'(got.red));
    if (got.red) begin
      check({tag, ".pc"},  64'(redirect_pc),  64'(got.pc));
      check({tag, ".fsq"}, 64'(redirect_fsq), 64'(got.fsq));
      check({tag, ".src"}, 64'(redirect_src), 64'(got.src));
    end
    check({tag, ".stall"}, 64'(fetch_stall), 64'(got.stall));
    check({tag, ".full"},  64'(ibuf_full),   64'(got.full));
    check({tag, ".count"}, 64'(ibuf_count),  64'(got.cnt));
  endtask

  task automatic idle(input logic e_stall, input logic e_full, input logic [5:0] e_cnt, input string tag);
    step(0, '0, '0, 0, '0, '0, 0, 0, 0, '0, '0, 0, e_stall, e_full, e_cnt, tag);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    be_redirect_en = 0; be_redirect_pc = '0; be_redirect_fsq = '0;
    pd_redirect_en = 0; pd_redirect_pc = '0; pd_redirect_fsq = '0;
    ibuf_push_num = '0; ibuf_pop_num = '0;
    #1;
    check("rst.redirect", 64'(redirect), 64'd0);
    check("rst.stall", 64'(fetch_stall), 64'd0);
    check("rst.full", 64'(ibuf_full), 64'd0);
    check("rst.count", 64'(ibuf_count), 64'd0);
    check("rst.pc", 64'(redirect_pc), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic backend redirect, 2-cycle flush window
    step(1, 39'h8000_1000, 5'd3, 0, '0, '0, 0, 0, 1, 39'h8000_1000, 5'd3, 0, 1, 0, 0, "be_basic");
    idle(1, 0, 0, "be_flush1");
    idle(0, 0, 0, "be_idle");

    // simultaneous be and pd: backend wins, pd dropped; later pd in FLUSH ignored
    step(1, 39'h0000_1234, 5'd7, 1, 39'h0000_5678, 5'd9, 0, 0, 1, 39'h0000_1234, 5'd7, 0, 1, 0, 0, "both");
    step(0, '0, '0, 1, 39'h0000_5678, 5'd9, 0, 0, 0, '0, '0, 0, 1, 0, 0, "pd_in_flush");
    idle(0, 0, 0, "after_both");

    // predecode redirect accepted in IDLE
    step(0, '0, '0, 1, 39'h40_0000_0040, 5'd12, 0, 0, 1, 39'h40_0000_0040, 5'd12, 1, 1, 0, 0, "pd_basic");
    idle(1, 0, 0, "pd_flush1");
    idle(0, 0, 0, "pd_idle");

    // fill the ibuf; full only once count exceeds 24
    step(0, '0, '0, 0, '0, '0, 8, 0, 0, '0, '0, 0, 0, 0, 8,  "fill8");
    step(0, '0, '0, 0, '0, '0, 8, 0, 0, '0, '0, 0, 0, 0, 16, "fill16");
    step(0, '0, '0, 0, '0, '0, 8, 0, 0, '0, '0, 0, 0, 0, 24, "fill24");
    step(0, '0, '0, 0, '0, '0, 8, 0, 0, '0, '0, 0, 0, 1, 32, "fill32");
    // pd rejected while full; count clamps at depth
    step(0, '0, '0, 1, 39'h0000_0abc, 5'd4, 8, 0, 0, '0, '0, 0, 0, 1, 32, "pd_full_clamp");
    step(0, '0, '0, 0, '0, '0, 0, 8, 0, '0, '0, 0, 0, 0, 24, "pop8");
    step(0, '0, '0, 0, '0, '0, 0, 4, 0, '0, '0, 0, 0, 0, 20, "pop4");

    // backend redirect clears occupancy regardless of push
    step(1, 39'h0000_2000, 5'd1, 0, '0, '0, 8, 0, 1, 39'h0000_2000, 5'd1, 0, 1, 0, 0, "be_clear");
    step(0, '0, '0, 0, '0, '0, 3, 1, 0, '0, '0, 0, 1, 0, 2, "push_in_flush");
    // backend in FLUSH re-pulses and reloads the window
    step(1, 39'h0000_3000, 5'd5, 0, '0, '0, 0, 0, 1, 39'h0000_3000, 5'd5, 0, 1, 0, 0, "be_repulse");
    step(0, '0, '0, 0, '0, '0, 5, 0, 0, '0, '0, 0, 1, 0, 5, "repulse_flush1");

    // async reset mid-FLUSH clears outputs without a clock edge
    rst = 1'b1;
    #1;
    check("midrst.redirect", 64'(redirect), 64'd0);
    check("midrst.stall", 64'(fetch_stall), 64'd0);
    check("midrst.count", 64'(ibuf_count), 64'd0);
    #2;
    rst = 1'b0;

    step(1, 39'h0000_7000, 5'd2, 0, '0, '0, 0, 0, 1, 39'h0000_7000, 5'd2, 0, 1, 0, 0, "post_rst_be");
    idle(1, 0, 0, "post_rst_flush1");
    idle(0, 0, 0, "post_rst_idle");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
